alu_exec_unit: RTL

//  Execute-stage ALU. Consumes the 4-bit ALU opcode produced by the ALU control decoder plus two

---
 rtl/alu_exec_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub ops and an iterative shift-add multiply,
// with valid/ready handshakes on both the operand and the result side.
module alu_exec_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready never looks at in_valid; out_valid/result/flags hold until out_ready is seen.

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_ORR    = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_PASS_B = 4'b0111;
  localparam logic [3:0] OP_MUL    = 4'b1000;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             drain;
  logic             is_mul;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic [3:0]       op_flags;

  logic [WIDTH-1:0] mul_sum;
  logic [3:0]       mul_flags;

  assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign busy     = (state == ST_MUL);
  assign is_mul   = (alu_op == OP_MUL);

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // Undefined opcodes fall into the default arm: result 0 yields flags 0100 naturally.
  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (alu_op)
      OP_AND:    op_res = a & b;
      OP_ORR:    op_res = a | b;
      OP_ADD: begin
        op_res = add_full[WIDTH-1:0];
        op_c   = add_full[WIDTH];
        op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = sub_full[WIDTH-1:0];
        op_c   = sub_full[WIDTH];
        op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_PASS_B: op_res = b;
      default:   op_res = '0;
    endcase
  end

  assign op_flags  = {op_res[WIDTH-1], (op_res == '0), op_c, op_v};

  assign mul_sum   = acc + (b_sh[0] ? a_sh : '0);
  assign mul_flags = {mul_sum[WIDTH-1], (mul_sum == '0), 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              // Any held result drains on this edge because in_ready required it.
              a_sh      <= a;
              b_sh      <= b;
              acc       <= '0;
              cnt       <= CNT_INIT;
              out_valid <= 1'b0;
              state     <= ST_MUL;
            end else begin
              result    <= op_res;
              flags     <= op_flags;
              out_valid <= 1'b1;
            end
          end else if (drain) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          acc  <= mul_sum;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          if (cnt == '0) begin
            result    <= mul_sum;
            flags     <= mul_flags;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
